// File: rtl/datatransfer_seq_if.sv
// Instruction handshake plus the datapath control bundle driven by datatransfer_seq.
// Optional instr_count member exists only when DATATRANSFER_SEQ_ICOUNT_EN is defined.
interface datatransfer_seq_if;
  logic       instr_valid;
  logic       instr_ready;
  logic       instr_mode;
  logic [2:0] instr_op;
  logic [4:0] instr_src1;
  logic [4:0] instr_src2;
  logic [4:0] instr_dst;
  logic       stall;
  logic [4:0] ReadAddr1;
  logic [4:0] ReadAddr2;
  logic       WriteEnable;
  logic [4:0] WriteAddr;
  logic       LD_A;
  logic       LD_B;
  logic       LD_C;
  logic       OEA;
  logic       OEB;
  logic       OEC;
  logic [1:0] SelMux;
  logic [2:0] opcode;
  logic       enableALU;
  logic       busy;
  logic       done;
`ifdef DATATRANSFER_SEQ_ICOUNT_EN
  logic [7:0] instr_count;
`endif

  modport master (
    output instr_valid, instr_mode, instr_op, instr_src1, instr_src2, instr_dst, stall,
    input  instr_ready, ReadAddr1, ReadAddr2, WriteEnable, WriteAddr,
    input  LD_A, LD_B, LD_C, OEA, OEB, OEC, SelMux, opcode, enableALU, busy, done
`ifdef DATATRANSFER_SEQ_ICOUNT_EN
    , input instr_count
`endif
  );

  modport slave (
    input  instr_valid, instr_mode, instr_op, instr_src1, instr_src2, instr_dst, stall,
    output instr_ready, ReadAddr1, ReadAddr2, WriteEnable, WriteAddr,
    output LD_A, LD_B, LD_C, OEA, OEB, OEC, SelMux, opcode, enableALU, busy, done
`ifdef DATATRANSFER_SEQ_ICOUNT_EN
    , output instr_count
`endif
  );
endinterface

// File: rtl/datatransfer_seq.sv
// READ -> EXEC -> WB micro-sequencer producing every DataTransfer datapath strobe.
// Define DATATRANSFER_SEQ_ICOUNT_EN to add the wrapping 8-bit completed-instruction counter.
module datatransfer_seq (
  input  logic              clk,
  input  logic              rst,
  datatransfer_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t     state_q, state_d;
  logic       mode_q, mode_d;
  logic [2:0] op_q, op_d;
  logic [4:0] src1_q, src1_d;
  logic [4:0] src2_q, src2_d;
  logic [4:0] dst_q, dst_d;

  logic       run;
  logic       ready;
  logic       accept;
  logic       ld_a, ld_b, ld_c;
  logic       oea, oeb, oec;
  logic [1:0] sel;
  logic [2:0] opc;
  logic       alu_en, we, done;

  assign run    = ~bus.stall;
  assign ready  = (state_q == IDLE) & ~rst & run;
  assign accept = bus.instr_valid & ready;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    op_d    = op_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    dst_d   = dst_q;
    if (run) begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            mode_d  = bus.instr_mode;
            op_d    = bus.instr_op;
            src1_d  = bus.instr_src1;
            src2_d  = bus.instr_src2;
            dst_d   = bus.instr_dst;
            state_d = READ;
          end
        end
        READ:    state_d = EXEC;
        EXEC:    state_d = WB;
        WB:      state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      op_q    <= 3'd0;
      src1_q  <= 5'd0;
      src2_q  <= 5'd0;
      dst_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      op_q    <= op_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      dst_q   <= dst_d;
    end
  end

  // Stall only masks the capturing strobes; bus drivers stay state-decoded so the bus is stable.
  always_comb begin
    ld_a   = 1'b0;
    ld_b   = 1'b0;
    ld_c   = 1'b0;
    oea    = 1'b0;
    oeb    = 1'b0;
    oec    = 1'b0;
    sel    = 2'd0;
    opc    = 3'd0;
    alu_en = 1'b0;
    we     = 1'b0;
    done   = 1'b0;
    unique case (state_q)
      READ: begin
        ld_a = run;
        ld_b = run & ~mode_q;
      end
      EXEC: begin
        oea  = 1'b1;
        ld_c = run;
        if (!mode_q) begin
          oeb    = 1'b1;
          opc    = op_q;
          alu_en = run;
          sel    = 2'd3;
        end
      end
      WB: begin
        oec  = 1'b1;
        sel  = 2'd2;
        we   = run;
        done = run;
      end
      default: ;
    endcase
  end

  assign bus.instr_ready = ready;
  assign bus.ReadAddr1   = src1_q;
  assign bus.ReadAddr2   = src2_q;
  assign bus.WriteAddr   = dst_q;
  assign bus.WriteEnable = we;
  assign bus.LD_A        = ld_a;
  assign bus.LD_B        = ld_b;
  assign bus.LD_C        = ld_c;
  assign bus.OEA         = oea;
  assign bus.OEB         = oeb;
  assign bus.OEC         = oec;
  assign bus.SelMux      = sel;
  assign bus.opcode      = opc;
  assign bus.enableALU   = alu_en;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done;

`ifdef DATATRANSFER_SEQ_ICOUNT_EN
  logic [7:0] icount_q, icount_d;

  assign icount_d = icount_q + {7'd0, done};

  always_ff @(posedge clk) begin
    if (rst) icount_q <= 8'd0;
    else     icount_q <= icount_d;
  end

  assign bus.instr_count = icount_q;
`endif

endmodule

// File: tb/tb_datatransfer_seq.sv
// Randomized + directed scoreboard bench for datatransfer_seq.
module tb_datatransfer_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  datatransfer_seq_if bus();
  datatransfer_seq dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic       mode;
    logic [2:0] op;
    logic [4:0] s1, s2, d;
    int         acc;
  } item_t;

  item_t sc[$];
  int npass = 0, ntot = 0, cyc = 0;
  int done_cnt = 0, done_since_rst = 0, stall_in_flight = 0, last_done_cyc = 0;
  bit rand_stall = 0, force_stall = 0;

  logic [4:0] o_ra1, o_ra2;
  logic       o_ldb, seen_r, seen_e, o_oea, o_oeb, o_en;
  logic [2:0] o_op;
  logic [1:0] o_sel;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    ntot++;
    $display("FAIL %s: got timeout/unexpected event expected none", nm);
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.ReadAddr1, bus.ReadAddr2, bus.WriteEnable, bus.WriteAddr, bus.LD_A, bus.LD_B,
                bus.LD_C, bus.OEA, bus.OEB, bus.OEC, bus.SelMux, bus.opcode, bus.enableALU,
                bus.busy, bus.done});
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    bus.stall = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.stall = rand_stall ? ($urandom_range(0, 3) == 0) : force_stall;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // Monitor: observe each phase, and close the transaction on the write-back strobe.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      sc.delete();
      seen_r = 0; seen_e = 0; stall_in_flight = 0; done_since_rst = 0;
    end else begin
      if (bus.stall) begin
        chk("stall_gate", 32'({bus.LD_A, bus.LD_B, bus.LD_C, bus.WriteEnable, bus.enableALU, bus.done}), 32'd0);
        if (sc.size() != 0) stall_in_flight++;
      end
      if (bus.WriteEnable || bus.done) chk("done_with_we", 32'(bus.done), 32'(bus.WriteEnable));
      if (bus.LD_A) begin
        o_ra1 = bus.ReadAddr1; o_ra2 = bus.ReadAddr2; o_ldb = bus.LD_B; seen_r = 1;
      end
      if (bus.LD_C) begin
        o_oea = bus.OEA; o_oeb = bus.OEB; o_en = bus.enableALU; o_op = bus.opcode;
        o_sel = bus.SelMux; seen_e = 1;
      end
      if (bus.done) begin
        done_cnt++;
        done_since_rst++;
        last_done_cyc = cyc;
      end
      if (bus.WriteEnable) begin
        if (sc.size() == 0) fail("orphan_write");
        else begin
          item_t it;
          it = sc.pop_front();
          chk("read_phase", 32'({seen_r, o_ra1, o_ra2, o_ldb}), 32'({1'b1, it.s1, it.s2, ~it.mode}));
          chk("exec_phase", 32'({seen_e, o_oea, o_oeb, o_en, o_op, o_sel}),
              32'({1'b1, 1'b1, ~it.mode, ~it.mode, (it.mode ? 3'd0 : it.op), (it.mode ? 2'd0 : 2'd3)}));
          chk("wb_phase", 32'({bus.WriteAddr, bus.SelMux, bus.OEC, bus.done}), 32'({it.d, 2'd2, 1'b1, 1'b1}));
          chk("latency", 32'(cyc - it.acc), 32'(3 + stall_in_flight));
        end
        seen_r = 0; seen_e = 0; stall_in_flight = 0;
      end
    end
  end

  task automatic issue(input logic m, input logic [2:0] op, input logic [4:0] s1, s2, d,
                       input bit hold, output int acc);
    bus.instr_mode = m; bus.instr_op = op;
    bus.instr_src1 = s1; bus.instr_src2 = s2; bus.instr_dst = d;
    bus.instr_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.instr_ready) begin
        acc = cyc;
        sc.push_back('{m, op, s1, s2, d, cyc});
        break;
      end
      @(posedge clk);
      #1;
    end
    if (acc < 0) fail("accept_timeout");
    @(posedge clk);
    #1;
    if (!hold) bus.instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (sc.size() == 0) break;
      @(posedge clk);
      #1;
    end
    if (sc.size() != 0) fail("drain_timeout");
  endtask

  task automatic issue_rand(input bit hold);
    int a;
    issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), hold, a);
  endtask

  initial begin
    int a0, a1, a2, d0;
    rst = 1'b1;
    bus.instr_valid = 1'b0; bus.instr_mode = 1'b0; bus.instr_op = 3'd0;
    bus.instr_src1 = 5'd0; bus.instr_src2 = 5'd0; bus.instr_dst = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs(), 32'd0);
    chk("reset_ready", 32'(bus.instr_ready), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.instr_ready), 32'd1);
    @(posedge clk); #1;

    issue(1'b0, 3'b010, 5'd5, 5'd9, 5'd12, 1'b0, a0);
    wait_idle();
    issue(1'b1, 3'b101, 5'd31, 5'd7, 5'd0, 1'b0, a0);
    wait_idle();

    d0 = done_cnt;
    issue(1'b0, 3'b001, 5'd1, 5'd2, 5'd3, 1'b1, a0);
    issue(1'b1, 3'b000, 5'd4, 5'd5, 5'd4, 1'b1, a1);
    issue(1'b0, 3'b110, 5'd7, 5'd7, 5'd7, 1'b0, a2);
    chk("b2b_gap1", 32'(a1 - a0), 32'd4);
    chk("b2b_gap2", 32'(a2 - a1), 32'd4);
    wait_idle();
    chk("b2b_done", 32'(done_cnt - d0), 32'd3);

    issue(1'b0, 3'b111, 5'd3, 5'd4, 5'd5, 1'b0, a0);
    @(posedge clk); #1; force_stall = 1;
    @(posedge clk); #1;
    @(posedge clk); #1; force_stall = 0;
    wait_idle();
    chk("stall_done_time", 32'(last_done_cyc - a0), 32'd5);

    d0 = done_cnt;
    issue(1'b0, 3'b011, 5'd8, 5'd9, 5'd10, 1'b0, a0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_outputs", outs(), 32'd0);
    chk("midrst_ready", 32'(bus.instr_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", 32'(bus.instr_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);

    rand_stall = 1;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      issue_rand(1'b0);
    end
    rand_stall = 0;
    @(posedge clk); #1;
    wait_idle();

`ifdef DATATRANSFER_SEQ_ICOUNT_EN
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 257; i++) issue_rand(1'b0);
    wait_idle();
    chk("instr_count", 32'(bus.instr_count), 32'(done_since_rst % 256));
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/datatransfer_seq.md
# datatransfer_seq

Micro-sequencer that drives the DataTransfer datapath: register file, A/B/C registers, tristate bus drivers, bus mux and ALU. It accepts one instruction at a time over a valid/ready handshake and runs it as a fixed READ → EXEC → WB sequence. It produces every control strobe the datapath needs, so the datapath's control inputs connect straight to this block. It issues one instruction every 4 cycles.

## Interface
- No parameters; all widths fixed by the datapath (32-entry × 8-bit file, 3-bit opcode).
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept an instruction
- instr_mode  in  1  0 = ALU op, 1 = copy
- instr_op  in  3  ALU opcode (ignored in copy mode)
- instr_src1 / instr_src2 / instr_dst  in  5 each  read/read/write file addresses
- stall  in  1  freeze sequencing
- ReadAddr1, ReadAddr2  out  5  file read addresses
- WriteEnable  out  1;  WriteAddr  out  5  file write port (integration routes QC to WriteData)
- LD_A, LD_B, LD_C  out  1 each  register loads
- OEA, OEB, OEC  out  1 each  tristate enables
- SelMux  out  2  bus mux select: 0 = A, 1 = B, 2 = C, 3 = ALU/hi-Z leg
- opcode  out  3;  enableALU  out  1  ALU control
- busy  out  1;  done  out  1  status; done is a 1-cycle pulse

## Operation
- States: IDLE, READ, EXEC, WB.
- The FSM and the latched instruction fields are registered; all outputs are Moore-decoded from them.
- **IDLE**
  - instr_ready = 1 (gated low while rst = 1).
  - On instr_valid & instr_ready: latch mode/op/src1/src2/dst, go to READ.
- **READ**
  - ReadAddr1 = src1, ReadAddr2 = src2, LD_A = 1.
  - LD_B = 1 only in ALU mode.
  - Next state: EXEC.
- **EXEC, ALU mode**
  - OEA = OEB = 1, opcode = op, enableALU = 1, SelMux = 3, LD_C = 1.
- **EXEC, copy mode**
  - OEA = 1, SelMux = 0, LD_C = 1, enableALU = 0.
- **WB**
  - OEC = 1, SelMux = 2, WriteEnable = 1, WriteAddr = dst, done = 1.
  - Next state: IDLE.
- Outputs not listed for a state are 0. Address outputs hold their last latched value, which is don't-care when unused.
- busy = 1 in READ, EXEC and WB.
- **stall = 1**
  - State and latched fields hold.
  - LD_*, WriteEnable, enableALU and done are forced to 0.
  - OE*, SelMux and addresses keep their state-decoded values so the bus stays stable.
  - In IDLE, stall forces instr_ready = 0; no accept occurs.
- src1 == dst or src2 == dst is legal. The file is read in READ and written only in WB, so no hazard exists.
- Reset mid-instruction: the instruction is dropped. No WriteEnable or done is issued for it, and the FSM returns to IDLE.

## Timing
- Reset values: state IDLE, instr_ready 0 during rst and 1 in the first cycle after, all other outputs 0, latched fields 0.
- Accept at edge N.
- READ runs in cycle N+1; LD_A/LD_B capture at its end.
- EXEC runs in N+2; LD_C captures the bus at its end.
- WB runs in N+3; the file write occurs at its end.
- IDLE with instr_ready = 1 in N+4, so back-to-back accept is possible at edge N+4.
- Each stalled cycle adds exactly one cycle of latency at the current state.
- The register file read is combinational: ReadAddr must be valid for the whole READ cycle.
- done is high exactly one non-stalled cycle per instruction, coincident with WriteEnable.

## Configuration
- DATATRANSFER_SEQ_ICOUNT_EN defined:
  - Adds output instr_count [7:0], reset to 0.
  - Increments on every done pulse; wraps from 255 to 0.
- Undefined: no port and no counter logic.

## Test plan
- **Reset:** hold rst 3 cycles mid-EXEC → all outputs 0, instr_ready 0; 1 cycle after release instr_ready = 1; no WriteEnable ever seen for the dropped instruction.
- **ALU op:** mode 0, op 3'b010, src1 5, src2 9, dst 12 →
  - N+1: LD_A = LD_B = 1, ReadAddr 5/9.
  - N+2: enableALU = 1, opcode 010, SelMux 3, LD_C = 1.
  - N+3: WriteEnable = 1, WriteAddr 12, done = 1.
- **Copy:** mode 1, src1 31, dst 0 → LD_B never asserted; EXEC has SelMux 0, OEA 1, enableALU 0; WB writes address 0.
- **Back-to-back:** instr_valid held high with 3 instructions → accepts at N, N+4, N+8; exactly 3 done pulses.
- **Stall:** stall high for 2 cycles during EXEC → state holds, LD_C = 0 during the stall, LD_C = 1 in the cycle after release, done at N+5.
- **Counter (macro on):** 257 instructions → instr_count = 1.
